piso_tx: RTL and testbench
==========================

# piso_tx

Parallel-in, serial-out transmitter. It accepts a WIDTH-bit word through a valid/ready handshake and shifts the word out one bit per clock on `sdo`, with framing strobes alongside. It is the transmit end of the lab's serial shift link: `sdo` drives the `d` input of the existing 4-bit SIPO receiver, and `sdo_valid` gates its capture. Back-to-back words stream with no idle gap.

## Interface
- `WIDTH`, default 4: word length in bits; must be ≥ 2.
- `MSB_FIRST`, default 1: 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.

- `clk`  in  1: clock; all state changes on the rising edge.
- `rst_n`  in  1: reset, synchronous and active-low.
- `load_valid`  in  1: `load_data` is offered this cycle.
- `load_data`  in  WIDTH: word to transmit; sampled only on handshake.
- `load_ready`  out  1: transmitter can accept a word this cycle.
- `sdo`  out  1: serial data out, registered.
- `sdo_valid`  out  1: `sdo` carries a payload bit this cycle.
- `sdo_last`  out  1: `sdo` carries the final bit of the current word.
- `done`  out  1: one-cycle pulse, asserted in the cycle after the last bit.

## Operation
- State machine with two states:
  - IDLE: no word in flight.
  - SHIFT: a word is being shifted out.
- Internal state:
  - `shreg`, WIDTH bits.
  - `bitcnt`, $clog2(WIDTH) bits, counting bits already sent in the current word.
- `load_ready` is combinational:
  - high in IDLE;
  - high in SHIFT only while `bitcnt == WIDTH-1` (last bit on the line);
  - low otherwise.
- Handshake: a word is accepted at an edge where `load_valid && load_ready`. `load_valid` while `load_ready` is low is ignored. The source must hold the word until it is accepted.
- On accept:
  - `shreg <= load_data`, `bitcnt <= 0`, state becomes SHIFT.
  - The first bit is driven on `sdo` at that same edge.
- Each SHIFT edge without accept:
  - If `bitcnt < WIDTH-1`: shift `shreg` toward the output end, fill with 0, `bitcnt++`.
  - If `bitcnt == WIDTH-1` and no new accept: go to IDLE and pulse `done`.
- Bit ordering:
  - MSB_FIRST=1: `sdo = shreg[WIDTH-1]`, shift left.
  - MSB_FIRST=0: `sdo = shreg[0]`, shift right.
- Output values:
  - `sdo_valid` = (state == SHIFT).
  - `sdo_last` = SHIFT && `bitcnt == WIDTH-1`.
  - In IDLE, `sdo` = 0.
- Back-to-back: an accept during the last-bit cycle reloads `shreg` and resets `bitcnt`, and the state stays SHIFT.
  - The next word's first bit follows the previous last bit with no gap.
  - `done` is NOT pulsed between streamed words; it pulses only on the transition to IDLE.
- `load_data` changes after accept have no effect on the word in flight.

## Timing
- Reset (`rst_n` low at an edge) takes priority over everything. At that edge:
  - State goes to IDLE; `shreg` and `bitcnt` go to 0.
  - `sdo`, `sdo_valid`, `sdo_last` and `done` all go to 0.
  - `load_ready` reads 1 in the cycle after reset.
- Reset mid-word aborts the word: no further bits and no `done`. A handshake coinciding with reset is dropped.
- Latency:
  - Accept at edge k puts bit 0 on `sdo` from edge k through edge k+1.
  - Bit i is present between edges k+i and k+i+1.
  - `sdo_last` is high between edges k+WIDTH-1 and k+WIDTH.
  - `done` is high between edges k+WIDTH and k+WIDTH+1 (standalone word only).
- Throughput: one word per WIDTH cycles when streaming.
- `sdo_valid` stays high continuously across a streamed sequence.

## Test plan
- **Reset values:** hold `rst_n`=0 for 2 edges, then release → `sdo`=`sdo_valid`=`sdo_last`=`done`=0 and `load_ready`=1.
- **Single word, MSB first:** WIDTH=4, MSB_FIRST=1, accept 4'b1010 at edge k →
  - `sdo` = 1,0,1,0 over the next 4 cycles;
  - `sdo_valid` high for exactly 4 cycles;
  - `sdo_last` high in the 4th;
  - `done` pulses for one cycle at edge k+4, then IDLE.
  - The SIPO receiver captures 4'b1010.
- **LSB first:** MSB_FIRST=0, accept 4'b1100 → `sdo` = 0,0,1,1.
- **Back-to-back:** `load_valid` held high with 4'b1001, then 4'b0110 →
  - `sdo` = 1,0,0,1,0,1,1,0 with no gap;
  - `sdo_valid` high for 8 contiguous cycles;
  - `load_ready` high only in the cycles where `sdo_last` is high;
  - a single `done` after the 8th bit.
- **Busy ignore:** after accepting 4'b1111, pulse `load_valid` with 4'b0000 during bits 1–2 → the request is ignored and `sdo` = 1,1,1,1.
- **Reset mid-word:** accept 4'b1011 and drive `rst_n`=0 at the edge after bit 1 → all outputs go to 0 at that edge, no `done` follows, and the next accept of 4'b0101 transmits 0,1,0,1 correctly.

Source files
------------

// File: rtl/piso_tx.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | piso_tx : parallel-in serial-out transmitter with valid/ready load and   |
// |           sdo/sdo_valid/sdo_last/done framing, back-to-back streaming.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module piso_tx #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             sdo,
    output logic             sdo_valid,
    output logic             sdo_last,
    output logic             done
);

    localparam int                  c_cnt_w    = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0]  c_last_bit = c_cnt_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0]  c_cnt_one  = c_cnt_w'(1);
    localparam int                  c_out_idx  = MSB_FIRST ? WIDTH - 1 : 0;

    localparam logic [0:0] c_st_idle  = 1'b0;
    localparam logic [0:0] c_st_shift = 1'b1;

    logic [0:0]         r_state;
    logic [WIDTH-1:0]   r_shreg;
    logic [c_cnt_w-1:0] r_bitcnt;
    logic               r_done;
    logic [WIDTH-1:0]   w_shifted;
    logic               w_on_last;
    logic               w_accept;

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_shifted = {r_shreg[WIDTH-2:0], 1'b0};
        end else begin : g_lsb_first
            assign w_shifted = {1'b0, r_shreg[WIDTH-1:1]};
        end
    endgenerate

    assign w_on_last  = (r_state == c_st_shift) && (r_bitcnt == c_last_bit);
    assign load_ready = (r_state == c_st_idle) || w_on_last;
    assign w_accept   = load_valid && load_ready;

    // shreg is cleared on the way to IDLE so sdo reads 0 there straight from the register
    assign sdo       = r_shreg[c_out_idx];
    assign sdo_valid = (r_state == c_st_shift);
    assign sdo_last  = w_on_last;
    assign done      = r_done;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= c_st_idle;
            r_shreg  <= '0;
            r_bitcnt <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_state  <= c_st_shift;
                r_shreg  <= load_data;
                r_bitcnt <= '0;
            end else if (r_state == c_st_shift) begin
                if (r_bitcnt == c_last_bit) begin
                    r_state  <= c_st_idle;
                    r_shreg  <= '0;
                    r_bitcnt <= '0;
                    r_done   <= 1'b1;
                end else begin
                    r_shreg  <= w_shifted;
                    r_bitcnt <= r_bitcnt + c_cnt_one;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_piso_tx.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | tb_piso_tx : scoreboard bench driving an MSB-first and an LSB-first      |
// |              piso_tx side by side with directed words.                   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_piso_tx;

    typedef struct packed {
        logic sdo;
        logic last;
        logic ready;
        logic done;
        logic chain;
    } item_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load_valid = 1'b0;
    logic [3:0] load_data = 4'b0000;
    logic [1:0] ready_w, sdo_w, valid_w, last_w, done_w;

    item_t q_m[$];
    item_t q_l[$];
    item_t mon_e;
    bit    prev_m = 1'b0;
    bit    prev_l = 1'b0;
    bit    mon_en = 1'b0;
    int    checks = 0;
    int    errors = 0;

    always #5 clk = ~clk;

    piso_tx #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_data(load_data),
        .load_ready(ready_w[0]), .sdo(sdo_w[0]), .sdo_valid(valid_w[0]),
        .sdo_last(last_w[0]), .done(done_w[0])
    );

    piso_tx #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_data(load_data),
        .load_ready(ready_w[1]), .sdo(sdo_w[1]), .sdo_valid(valid_w[1]),
        .sdo_last(last_w[1]), .done(done_w[1])
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Each output cycle (sdo_valid or done) consumes one expected item; chain demands no gap before it.
    always @(negedge clk) begin
        if (mon_en) begin
            if (valid_w[0] || done_w[0]) begin
                if (q_m.size() == 0) begin
                    chk("msb_unexpected_output", 32'({valid_w[0], done_w[0]}), 32'd0);
                end else begin
                    mon_e = q_m.pop_front();
                    chk("msb_sdo_last_ready_done",
                        32'({sdo_w[0], last_w[0], ready_w[0], done_w[0]}),
                        32'({mon_e.sdo, mon_e.last, mon_e.ready, mon_e.done}));
                    if (mon_e.chain) chk("msb_no_gap", 32'(prev_m), 32'd1);
                end
            end
            prev_m = valid_w[0] || done_w[0];
            if (valid_w[1] || done_w[1]) begin
                if (q_l.size() == 0) begin
                    chk("lsb_unexpected_output", 32'({valid_w[1], done_w[1]}), 32'd0);
                end else begin
                    mon_e = q_l.pop_front();
                    chk("lsb_sdo_last_ready_done",
                        32'({sdo_w[1], last_w[1], ready_w[1], done_w[1]}),
                        32'({mon_e.sdo, mon_e.last, mon_e.ready, mon_e.done}));
                    if (mon_e.chain) chk("lsb_no_gap", 32'(prev_l), 32'd1);
                end
            end
            prev_l = valid_w[1] || done_w[1];
        end
    end

    // seq_m/seq_l list the expected serial bits, bit 3 first on the line.
    task automatic send_word(input logic [3:0] data, input logic [3:0] seq_m,
                             input logic [3:0] seq_l, input int nbits,
                             input bit chained, input bit with_done);
        item_t it;
        bit    ok;
        for (int i = 0; i < nbits; i++) begin
            it.last  = (i == 3);
            it.ready = (i == 3);
            it.done  = 1'b0;
            it.chain = (i == 0) ? chained : 1'b1;
            it.sdo   = seq_m[3-i];
            q_m.push_back(it);
            it.sdo   = seq_l[3-i];
            q_l.push_back(it);
        end
        if (with_done) begin
            it = '{sdo: 1'b0, last: 1'b0, ready: 1'b1, done: 1'b1, chain: 1'b1};
            q_m.push_back(it);
            q_l.push_back(it);
        end
        load_valid = 1'b1;
        load_data  = data;
        ok = 1'b0;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            ok = ready_w[0];
            @(posedge clk);
        end
        if (!ok) chk("accept_timeout", 32'(ok), 32'd1);
        #1 load_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 40 && (q_m.size() != 0 || q_l.size() != 0); n++) @(posedge clk);
        repeat (3) @(posedge clk);
        chk("queues_drained", 32'(q_m.size() + q_l.size()), 32'd0);
        #1;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_sdo"},        32'(sdo_w),   32'd0);
        chk({tag, "_sdo_valid"},  32'(valid_w), 32'd0);
        chk({tag, "_sdo_last"},   32'(last_w),  32'd0);
        chk({tag, "_done"},       32'(done_w),  32'd0);
        chk({tag, "_load_ready"}, 32'(ready_w), 32'd3);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
        check_idle("reset");
        @(posedge clk);
        #1;

        // single words
        send_word(4'b1010, 4'b1010, 4'b0101, 4, 1'b0, 1'b1);
        drain();
        send_word(4'b1100, 4'b1100, 4'b0011, 4, 1'b0, 1'b1);
        drain();

        // back-to-back stream, done only after the second word
        send_word(4'b1001, 4'b1001, 4'b1001, 4, 1'b0, 1'b0);
        send_word(4'b0110, 4'b0110, 4'b0110, 4, 1'b1, 1'b1);
        drain();

        // request during bits 1-2 must be ignored
        send_word(4'b1111, 4'b1111, 4'b1111, 4, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        load_valid = 1'b1;
        load_data  = 4'b0000;
        @(posedge clk);
        @(posedge clk);
        #1 load_valid = 1'b0;
        drain();

        // reset at the edge after bit 1 aborts the word
        send_word(4'b1011, 4'b1011, 4'b1101, 2, 1'b0, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_idle("midword_reset");
        repeat (6) @(posedge clk);
        #1;
        chk("midword_queues_empty", 32'(q_m.size() + q_l.size()), 32'd0);
        send_word(4'b0101, 4'b0101, 4'b1010, 4, 1'b0, 1'b1);
        drain();

        @(negedge clk);
        check_idle("final");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
